// File: rtl/hex_pkg.sv
// Shared constants and types for the six-digit scrolling display sequencer.
package hex_pkg;

    localparam int GLYPH_W    = 5;
    localparam int NUM_DIGITS = 6;

    localparam logic [GLYPH_W-1:0] GLY_BLANK = 5'd16;
    localparam logic [GLYPH_W-1:0] GLY_DASH  = 5'd17;

    localparam logic [7:0] SEG_ALL_ON = 8'hFF;
    localparam logic [7:0] SEG_OFF    = 8'h00;

    typedef enum logic [1:0] {
        LAMP  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } scroll_state_e;

endpackage

// File: rtl/hex_glyph_dec.sv
// Combinational glyph-code to segment decoder: bit7=a .. bit1=g, bit0=dp (always off here).
module hex_glyph_dec
    import hex_pkg::*;
(
    input  logic [GLYPH_W-1:0] glyph,
    output logic [7:0]         seg
);

    always_comb begin
        seg = SEG_OFF;
        case (glyph)
            5'd0:      seg = 8'hFC;
            5'd1:      seg = 8'h60;
            5'd2:      seg = 8'hDA;
            5'd3:      seg = 8'hF2;
            5'd4:      seg = 8'h66;
            5'd5:      seg = 8'hB6;
            5'd6:      seg = 8'hBE;
            5'd7:      seg = 8'hE0;
            5'd8:      seg = 8'hFE;
            5'd9:      seg = 8'hF6;
            5'd10:     seg = 8'hEE;
            5'd11:     seg = 8'h3E;
            5'd12:     seg = 8'h9C;
            5'd13:     seg = 8'h7A;
            5'd14:     seg = 8'h9E;
            5'd15:     seg = 8'h8E;
            GLY_BLANK: seg = SEG_OFF;
            GLY_DASH:  seg = 8'h02;
            default:   seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/hex_scroll_ctrl.sv
// Scrolls a fixed glyph message across HEX5..HEX0, with lamp test after reset and a
// debounced pause/resume button on KEY[1]. KEY[0] is the asynchronous active-low reset.
module hex_scroll_ctrl
    import hex_pkg::*;
#(
    parameter int STEP_CYCLES = 12_500_000,
    parameter int DB_CYCLES   = 500_000,
    parameter int MSG_LEN     = 16,
    parameter logic [MSG_LEN*GLYPH_W-1:0] MSG = {
        5'd15, 5'd14, 5'd13, 5'd12, 5'd11, 5'd10, 5'd9, 5'd8,
        5'd7,  5'd6,  5'd5,  5'd4,  5'd3,  5'd2,  5'd1, 5'd0
    }
) (
    input  logic       MAX10_CLK1_50,
    input  logic [1:0] KEY,
    output logic [7:0] HEX0,
    output logic [7:0] HEX1,
    output logic [7:0] HEX2,
    output logic [7:0] HEX3,
    output logic [7:0] HEX4,
    output logic [7:0] HEX5
);

    localparam int PRE_W = $clog2(STEP_CYCLES);
    localparam int DB_W  = $clog2(DB_CYCLES);
    localparam int POS_W = $clog2(MSG_LEN);
    localparam int IDX_W = POS_W + 1;

    logic rst_n;
    assign rst_n = KEY[0];

    logic [1:0]       sync_q, sync_d;
    logic             db_level_q, db_level_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic             press_evt;
    logic [PRE_W-1:0] presc_q, presc_d;
    logic             tick;
    logic [POS_W-1:0] pos_q, pos_d;
    scroll_state_e    state_q, state_d;
    logic [7:0]       hex_q [NUM_DIGITS];
    logic [7:0]       hex_d [NUM_DIGITS];
    logic [7:0]       seg [NUM_DIGITS];
    logic [GLYPH_W-1:0] msg_glyph [MSG_LEN];
    logic [GLYPH_W-1:0] digit_glyph [NUM_DIGITS];

    // Button path: sync_q[1] is the synchronised level; a press is the accepted 1->0 change.
    always_comb begin
        sync_d     = {sync_q[0], KEY[1]};
        db_level_d = db_level_q;
        db_cnt_d   = '0;
        press_evt  = 1'b0;
        if (sync_q[1] != db_level_q) begin
            if (db_cnt_q == DB_W'(DB_CYCLES - 1)) begin
                db_level_d = sync_q[1];
                press_evt  = ~sync_q[1];
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    always_comb begin
        tick    = (presc_q == PRE_W'(STEP_CYCLES - 1));
        presc_d = tick ? '0 : presc_q + PRE_W'(1);
        state_d = state_q;
        pos_d   = pos_q;
        case (state_q)
            LAMP: begin
                if (tick) begin
                    state_d = RUN;
                    pos_d   = '0;
                end
            end
            RUN: begin
                // A press landing on the tick cycle wins: no advance, straight to PAUSE.
                if (press_evt) begin
                    state_d = PAUSE;
                    presc_d = '0;
                end else if (tick) begin
                    pos_d = (pos_q == POS_W'(MSG_LEN - 1)) ? '0 : pos_q + POS_W'(1);
                end
            end
            PAUSE: begin
                presc_d = '0;
                if (press_evt) begin
                    state_d = RUN;
                end
            end
            default: state_d = LAMP;
        endcase
    end

    for (genvar g = 0; g < MSG_LEN; g++) begin : g_msg
        assign msg_glyph[g] = MSG[g*GLYPH_W +: GLYPH_W];
    end

    // HEXk shows glyph (pos + 5 - k) mod MSG_LEN; one conditional subtract suffices since pos+5 < 2*MSG_LEN.
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        logic [IDX_W-1:0] raw_idx;
        logic [IDX_W-1:0] wrap_idx;
        assign raw_idx  = {1'b0, pos_q} + IDX_W'(NUM_DIGITS - 1 - k);
        assign wrap_idx = (raw_idx >= IDX_W'(MSG_LEN)) ? raw_idx - IDX_W'(MSG_LEN) : raw_idx;
        assign digit_glyph[k] = msg_glyph[wrap_idx[POS_W-1:0]];

        hex_glyph_dec u_dec (
            .glyph (digit_glyph[k]),
            .seg   (seg[k])
        );
    end

    always_comb begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
            hex_d[k] = (state_q == LAMP) ? SEG_ALL_ON : seg[k];
        end
        if (state_q == PAUSE) begin
            hex_d[0][0] = 1'b1;
        end
    end

    always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= 2'b11;
            db_level_q <= 1'b1;
            db_cnt_q   <= '0;
            presc_q    <= '0;
            pos_q      <= '0;
            state_q    <= LAMP;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                hex_q[k] <= SEG_OFF;
            end
        end else begin
            sync_q     <= sync_d;
            db_level_q <= db_level_d;
            db_cnt_q   <= db_cnt_d;
            presc_q    <= presc_d;
            pos_q      <= pos_d;
            state_q    <= state_d;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                hex_q[k] <= hex_d[k];
            end
        end
    end

    assign HEX0 = hex_q[0];
    assign HEX1 = hex_q[1];
    assign HEX2 = hex_q[2];
    assign HEX3 = hex_q[3];
    assign HEX4 = hex_q[4];
    assign HEX5 = hex_q[5];

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Bench for hex_scroll_ctrl: a cycle-level behavioural model predicts every post-edge
// display value into a queue; a negedge monitor pops and compares.
module tb_hex_scroll_ctrl;

    localparam int STEP = 8;
    localparam int DB   = 4;
    localparam int LEN  = 16;

    logic       clk = 1'b0;
    logic [1:0] key;
    logic [7:0] hex0, hex1, hex2, hex3, hex4, hex5;

    always #5 clk = ~clk;

    hex_scroll_ctrl #(
        .STEP_CYCLES (STEP),
        .DB_CYCLES   (DB)
    ) dut (
        .MAX10_CLK1_50 (clk),
        .KEY           (key),
        .HEX0          (hex0),
        .HEX1          (hex1),
        .HEX2          (hex2),
        .HEX3          (hex3),
        .HEX4          (hex4),
        .HEX5          (hex5)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [47:0] exp_q[$];

    // Lit segments of each hex digit, by letter.
    string seg_str [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                            "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    function automatic logic [7:0] seg_of(input int digit);
        logic [7:0] r;
        string s;
        int idx;
        r = 8'h00;
        s = seg_str[digit];
        for (int i = 0; i < s.len(); i++) begin
            idx = int'(s[i]) - 97;
            r[7 - idx] = 1'b1;
        end
        return r;
    endfunction

    typedef enum {M_LAMP, M_RUN, M_PAUSE} mode_e;
    mode_e m_mode = M_LAMP;
    int    m_pos  = 0;
    int    m_next = 0;
    int    m_n    = 0;
    bit    m_level = 1'b1;
    bit    hist[$];

    // The default message holds glyph i at index i, so the digit shown equals the index.
    function automatic logic [47:0] model_display();
        logic [47:0] v;
        logic [7:0]  d;
        v = '0;
        for (int k = 0; k < 6; k++) begin
            if (m_mode == M_LAMP) d = 8'hFF;
            else                  d = seg_of((m_pos + 5 - k) % LEN);
            if (k == 0 && m_mode == M_PAUSE) d[0] = 1'b1;
            v[k*8 +: 8] = d;
        end
        return v;
    endfunction

    // Reference model: one update per rising edge, in absolute edge numbers.
    always @(posedge clk) begin
        bit all_diff;
        bit press;
        m_n++;
        if (!key[0]) begin
            exp_q.push_back(48'h0);
            m_mode  = M_LAMP;
            m_pos   = 0;
            m_next  = m_n + STEP;
            m_level = 1'b1;
            hist    = {};
            for (int i = 0; i < 8; i++) hist.push_back(1'b1);
        end else begin
            exp_q.push_back(model_display());
            hist.push_back(key[1]);
            if (hist.size() > 16) void'(hist.pop_front());
            // Debounced level changes once the button sampled 2..DB+1 edges ago all disagree with it.
            all_diff = 1'b1;
            for (int j = 2; j < 2 + DB; j++) begin
                if (hist[hist.size() - 1 - j] == m_level) all_diff = 1'b0;
            end
            press = all_diff && m_level;
            if (all_diff) m_level = !m_level;
            case (m_mode)
                M_LAMP: begin
                    if (m_n == m_next) begin
                        m_mode = M_RUN;
                        m_pos  = 0;
                        m_next = m_next + STEP;
                    end
                end
                M_RUN: begin
                    if (press) begin
                        m_mode = M_PAUSE;
                    end else if (m_n == m_next) begin
                        m_pos  = (m_pos + 1) % LEN;
                        m_next = m_next + STEP;
                    end
                end
                default: begin
                    if (press) begin
                        m_mode = M_RUN;
                        m_next = m_n + STEP;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [47:0] exp_v;
            logic [47:0] got;
            exp_v = exp_q.pop_front();
            got   = {hex5, hex4, hex3, hex2, hex1, hex0};
            n_checks++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL hex_display edge %0d: got %h expected %h", m_n, got, exp_v);
            end
        end
    end

    task automatic press_key(input int low_cycles);
        @(posedge clk);
        #2 key[1] = 1'b0;
        repeat (low_cycles) @(posedge clk);
        #2 key[1] = 1'b1;
    endtask

    task automatic async_reset_check();
        logic [47:0] got;
        @(negedge clk);
        #1 key[0] = 1'b0;
        #1;
        got = {hex5, hex4, hex3, hex2, hex1, hex0};
        n_checks++;
        if (got !== 48'h0) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected %h", got, 48'h0);
        end
        repeat (3) @(posedge clk);
        #2 key[0] = 1'b1;
    endtask

    initial begin
        int guard;
        key = 2'b10;
        repeat (3) @(posedge clk);
        #2 key[0] = 1'b1;

        // Lamp test plus 16 full steps (wrap included).
        repeat (STEP + 16 * STEP + 4) @(posedge clk);

        // Pause, hold frozen, resume.
        press_key(10);
        repeat (50) @(posedge clk);
        press_key(10);
        repeat (30) @(posedge clk);

        // Short glitch must be rejected.
        press_key(3);
        repeat (20) @(posedge clk);

        // Place the press event on the same edge as a step.
        guard = 0;
        do begin
            @(posedge clk);
            #2;
            guard++;
        end while (!(m_mode == M_RUN && (m_next - m_n) == 6) && guard < 40);
        n_checks++;
        if (guard >= 40) begin
            n_fail++;
            $display("FAIL tick_align: got %0d cycles searched, required < %0d", guard, 40);
        end
        key[1] = 1'b0;
        repeat (6) @(posedge clk);
        #2 key[1] = 1'b1;
        repeat (20) @(posedge clk);
        press_key(10);
        repeat (20) @(posedge clk);

        // Reset while paused, then lamp test again from pos 0.
        press_key(10);
        repeat (20) @(posedge clk);
        async_reset_check();
        repeat (STEP + 3 * STEP + 4) @(posedge clk);

        // Random button activity.
        for (int i = 0; i < 12; i++) begin
            press_key($urandom_range(1, 10));
            repeat ($urandom_range(4, 40)) @(posedge clk);
        end

        repeat (5) @(posedge clk);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
